// File: rtl/amplitude_pkg.sv
// Shared definitions for the amplitude RAM passes: sizes, phase encodings,
// FSM state type and the unit-phase complex multiply.
package amplitude_pkg;

  localparam int NUM_QUBIT   = 4;
  localparam int COMPLEX_BIT = 24;

  localparam logic signed [1:0] PH_POS1 = 2'sd1;
  localparam logic signed [1:0] PH_NEG1 = -2'sd1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} rd_state_e;

  // Multiply {re,im} by one of +1/-1/+i/-i. alpha_r wins over alpha_i; any
  // other code passes the sample through. Negation wraps at COMPLEX_BIT, so
  // the most negative value maps to itself. The update pass calls this with
  // the conjugate phase to undo it.
  function automatic logic [2*COMPLEX_BIT-1:0] cmul_unit_phase(
    input logic [2*COMPLEX_BIT-1:0] data,
    input logic signed [1:0]        a_r,
    input logic signed [1:0]        a_i
  );
    logic [COMPLEX_BIT-1:0] re, im, nre, nim;
    logic [2*COMPLEX_BIT-1:0] res;
    re  = data[2*COMPLEX_BIT-1:COMPLEX_BIT];
    im  = data[COMPLEX_BIT-1:0];
    nre = -re;
    nim = -im;
    if (a_r == PH_POS1)      res = {re, im};
    else if (a_r == PH_NEG1) res = {nre, nim};
    else if (a_i == PH_POS1) res = {nim, re};
    else if (a_i == PH_NEG1) res = {im, nre};
    else                     res = {re, im};
    return res;
  endfunction

endpackage

// File: rtl/amplitude_phase_stream_out_if.sv
// RAM read port plus output stream of the amplitude readout block.
interface amplitude_phase_stream_out_if
  import amplitude_pkg::*;
#(
  parameter int num_qubit   = NUM_QUBIT,
  parameter int complex_bit = COMPLEX_BIT
) ();

  logic                     ram_rd_en;
  logic [num_qubit-1:0]     ram_rd_addr;
  logic [2*complex_bit-1:0] ram_rd_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [2*complex_bit-1:0] out_data;
  logic [num_qubit-1:0]     out_index;
  logic                     out_last;

  modport master (
    output ram_rd_en, ram_rd_addr, input ram_rd_data,
    output out_valid, out_data, out_index, out_last, input out_ready
  );

  modport slave (
    input ram_rd_en, ram_rd_addr, output ram_rd_data,
    input out_valid, out_data, out_index, out_last, output out_ready
  );

endinterface

// File: rtl/amp_skid_fifo2.sv
// Two-entry valid/ready FIFO; the head is presented directly on the outputs.
module amp_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_q, rd_q;
  logic [1:0]            occ_q;
  logic                  push_ok, pop_ok;

  assign head_valid = (occ_q != 2'd0);
  assign head_data  = mem_q[rd_q];
  assign occ        = occ_q;
  assign pop_ok     = pop & head_valid;
  assign push_ok    = push & ((occ_q != 2'd2) | pop_ok);

  // Storage, pointers and occupancy; push+pop together leaves occupancy as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_q] <= push_data;
      wr_q  <= wr_q ^ push_ok;
      rd_q  <= rd_q ^ pop_ok;
      occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/amplitude_phase_stream_out.sv
// Streams the settled amplitude RAM out in index order, re-applying the
// global phase alpha, with a 2-entry skid buffer for backpressure.
module amplitude_phase_stream_out
  import amplitude_pkg::*;
#(
  parameter int num_qubit   = NUM_QUBIT,
  parameter int complex_bit = COMPLEX_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           count,
  input  logic signed [1:0]     alpha_r,
  input  logic signed [1:0]     alpha_i,
  output logic                  busy,
  output logic                  done,
  amplitude_phase_stream_out_if.master bus
);

  localparam int DW = 2*complex_bit;
  localparam int PW = num_qubit + 1;
  localparam int FW = 1 + num_qubit + DW;
  localparam logic [PW-1:0] MAX_CNT = {1'b1, {num_qubit{1'b0}}};

  rd_state_e              state_q, state_d;
  logic [PW-1:0]          rd_ptr_q, cnt_q, cnt_in;
  logic signed [1:0]      ar_q, ai_q;
  logic                   infl_q, infl_last_q;
  logic [num_qubit-1:0]   infl_idx_q;
  logic                   rd_en, pop;
  logic [1:0]             occ;
  logic [2:0]             pend;
  logic [FW-1:0]          push_data, head;

  assign cnt_in = (count > 32'(MAX_CNT)) ? MAX_CNT : count[PW-1:0];
  assign pop    = bus.out_valid & bus.out_ready;
  // Slots still needed after this cycle's pop: never let buffer + in-flight exceed 2.
  assign pend   = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_ptr_q[num_qubit-1:0];
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);

  // Next state and read issue.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (cnt_in == '0) ? ST_FIN : ST_RUN;
      ST_RUN: begin
        if (rd_ptr_q == cnt_q) state_d = ST_DRAIN;
        else if (pend < 3'd2) begin
          rd_en = 1'b1;
          if (rd_ptr_q == cnt_q - 1'b1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if ((pop && bus.out_last) || (occ == 2'd0 && !infl_q)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Pass parameters, read pointer and tag of the read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ar_q        <= '0;
      ai_q        <= '0;
      rd_ptr_q    <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        cnt_q    <= cnt_in;
        ar_q     <= alpha_r;
        ai_q     <= alpha_i;
        rd_ptr_q <= '0;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      infl_q <= rd_en;
      if (rd_en) begin
        infl_idx_q  <= rd_ptr_q[num_qubit-1:0];
        infl_last_q <= (rd_ptr_q == cnt_q - 1'b1);
      end
    end
  end

  assign push_data = {infl_last_q, infl_idx_q, cmul_unit_phase(bus.ram_rd_data, ar_q, ai_q)};

  amp_skid_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (infl_q),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (bus.out_valid),
    .head_data  (head),
    .occ        (occ)
  );

  assign {bus.out_last, bus.out_index, bus.out_data} = head;

endmodule

// File: tb/tb_amplitude_phase_stream_out.sv
// Directed bench for amplitude_phase_stream_out: RAM model, beat collector,
// stall-stability and outstanding-read monitors, hand-computed expectations.
module tb_amplitude_phase_stream_out;
  import amplitude_pkg::*;

  localparam int NQ = 4;
  localparam int CB = 24;
  localparam int DW = 2*CB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       count = '0;
  logic signed [1:0] alpha_r = '0;
  logic signed [1:0] alpha_i = '0;
  logic              busy, done;

  amplitude_phase_stream_out_if #(.num_qubit(NQ), .complex_bit(CB)) bus ();

  amplitude_phase_stream_out #(.num_qubit(NQ), .complex_bit(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .alpha_r(alpha_r), .alpha_i(alpha_i), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) if (bus.ram_rd_en) ram_q <= mem[bus.ram_rd_addr];
  assign bus.ram_rd_data = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int            b_idx[$];
  logic [DW-1:0] b_dat[$];
  bit            b_last[$];
  int            b_cyc[$];
  int            done_cyc, done_cnt, rd_cnt, valid_cnt, outst, s_cyc;
  bit            ovf, hold;
  logic [63:0]   held;

  // Collector and protocol monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold  = 1'b0;
      outst = 0;
    end else begin
      if (bus.ram_rd_en) rd_cnt++;
      if (bus.out_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (hold) chk("stall_hold", {10'd0, bus.out_valid, bus.out_last, bus.out_index, bus.out_data}, held);
      hold = bus.out_valid & !bus.out_ready;
      held = {10'd0, bus.out_valid, bus.out_last, bus.out_index, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        b_idx.push_back(int'(bus.out_index));
        b_dat.push_back(bus.out_data);
        b_last.push_back(bus.out_last);
        b_cyc.push_back(cyc);
      end
      outst = outst + int'(bus.ram_rd_en) - int'(bus.out_valid & bus.out_ready);
      if (outst > 2) ovf = 1'b1;
    end
  end

  task automatic clr();
    b_idx.delete(); b_dat.delete(); b_last.delete(); b_cyc.delete();
    done_cyc = -1; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; ovf = 1'b0;
  endtask

  task automatic run_pass(input logic [31:0] cnt, input logic signed [1:0] ar,
                          input logic signed [1:0] ai, input bit rnd, input bit poke);
    int t;
    clr();
    @(posedge clk); #1;
    start = 1'b1; count = cnt; alpha_r = ar; alpha_i = ai; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    s_cyc = cyc; start = 1'b0; count = '0; alpha_r = '0; alpha_i = '0;
    chk("busy_after_start", busy, 1);
    t = 0;
    while (done_cyc < 0 && t < 300) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && t == 5) begin start = 1'b1; count = 32'd3; alpha_r = -2'sd1; end
      else begin start = 1'b0; count = '0; alpha_r = '0; end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0; count = '0; alpha_r = '0; bus.out_ready = 1'b1;
    chk("done_seen", done_cyc >= 0, 1);
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done_cnt, 1);
  endtask

  task automatic check_beats(input int n, input bit neg);
    logic [CB-1:0] re, im;
    chk("beat_count", b_idx.size(), n);
    for (int i = 0; i < n && i < b_idx.size(); i++) begin
      re = mem[i][DW-1:CB];
      im = mem[i][CB-1:0];
      if (neg) begin re = -re; im = -im; end
      chk("beat_index", b_idx[i], i);
      chk("beat_data", b_dat[i], {re, im});
      chk("beat_last", b_last[i], (i == n-1));
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[i] = {24'(i+1), 24'(-(i+1))};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    fill_ramp();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rd_en", bus.ram_rd_en, 0);
    chk("rst_outs", {bus.out_last, bus.out_index, bus.out_data}, 0);
    rst = 1'b0;

    // 4 entries, phase +1, full throughput.
    run_pass(32'd4, 2'sd1, 2'sd0, 1'b0, 1'b0);
    check_beats(4, 1'b0);
    chk("t1_rd_cnt", rd_cnt, 4);
    for (int i = 0; i < 4 && i < b_cyc.size(); i++) chk("t1_beat_cyc", b_cyc[i], s_cyc + 2 + i);
    chk("t1_done_cyc", done_cyc, s_cyc + 6);

    // Quadrant phases on {100,7}.
    mem[0] = {24'd100, 24'd7};
    run_pass(32'd2, 2'sd0, 2'sd1, 1'b0, 1'b0);
    chk("t2_pos_i", b_dat[0], {24'hFFFFF9, 24'd100});
    run_pass(32'd2, 2'sd0, -2'sd1, 1'b0, 1'b0);
    chk("t2_neg_i", b_dat[0], {24'd7, 24'hFFFF9C});
    run_pass(32'd2, -2'sd1, 2'sd0, 1'b0, 1'b0);
    chk("t2_neg_1", b_dat[0], {24'hFFFF9C, 24'hFFFFF9});

    // 16 entries under random backpressure, stray start mid-pass.
    fill_ramp();
    run_pass(32'd16, 2'sd0, 2'sd0, 1'b1, 1'b1);
    check_beats(16, 1'b0);
    chk("t3_rd_cnt", rd_cnt, 16);
    chk("t3_outstanding_ok", ovf, 0);

    // Empty pass.
    run_pass(32'd0, 2'sd1, 2'sd0, 1'b0, 1'b0);
    chk("t4_valid_cnt", valid_cnt, 0);
    chk("t4_rd_cnt", rd_cnt, 0);
    chk("t4_done_cyc", done_cyc, s_cyc);

    // Clamp to 16 and wrap of the most negative value.
    mem[0] = {24'h800000, 24'd5};
    run_pass(32'd20, -2'sd1, 2'sd0, 1'b0, 1'b0);
    check_beats(16, 1'b1);
    chk("t5_wrap", b_dat[0], {24'h800000, 24'hFFFFFB});
    chk("t5_last_idx", b_idx[15], 15);

    // Reset in the middle of an 8-entry pass, then a clean rerun.
    fill_ramp();
    clr();
    @(posedge clk); #1;
    start = 1'b1; count = 32'd8; alpha_r = 2'sd1;
    @(posedge clk); #1;
    start = 1'b0; count = '0; alpha_r = '0;
    t = 0;
    while (b_idx.size() < 3 && t < 50) begin @(negedge clk); t++; end
    chk("t6_three_beats", b_idx.size(), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_rd_en", bus.ram_rd_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_outs", {bus.out_last, bus.out_index, bus.out_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_idle", busy, 0);
    run_pass(32'd8, 2'sd1, 2'sd0, 1'b0, 1'b0);
    check_beats(8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
